// File: rtl/irq_hs_arbiter_pkg.sv
// Shared types and codes for the multi-channel interrupt handshake arbiter.
// The cc_mux and uscite encodings feed the existing interrupt mux and status logic.
package irq_hs_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_WAIT   = 3'd1,
    S_INTR_1 = 3'd2,
    S_ENIN   = 3'd3,
    S_ENIN_W = 3'd4,
    S_INTR   = 3'd5,
    S_INTR_W = 3'd6
  } state_t;

  localparam logic [1:0] CC_ENIN  = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;

  localparam logic [1:0] OUT_NORM = 2'b01;
  localparam logic [1:0] US_HOLD  = 2'b00;
  localparam logic [1:0] US_INTR  = 2'b11;

endpackage

// File: rtl/irq_hs_arbiter_if.sv
// Request/handshake bundle between peripherals and the arbiter.
// The master side drives requests and cont_eql; the slave (arbiter) drives everything else.
interface irq_hs_arbiter_if
  import irq_hs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
  logic [NUM_CH-1:0] req;
  logic              cont_eql;
  logic [1:0]        cc_mux;
  logic [1:0]        uscite;
  logic              enable_count;
  logic              ackout;
  logic [ID_W-1:0]   grant_id;
  logic              busy;
  logic              timeout_err;
  logic [CNT_W-1:0]  svc_count;

  modport master (
    output req, cont_eql,
    input  cc_mux, uscite, enable_count, ackout, grant_id, busy, timeout_err, svc_count
  );

  modport slave (
    input  req, cont_eql,
    output cc_mux, uscite, enable_count, ackout, grant_id, busy, timeout_err, svc_count
  );
endinterface

// File: rtl/irq_hs_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning circularly upward from i_ptr.
// Purely combinational so it can be exercised on its own.
module rr_pick
  import irq_hs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [ID_W-1:0]   i_ptr,
  output logic              o_found,
  output logic [ID_W-1:0]   o_idx
);
  logic [ID_W-1:0] w_pos;

  // Scan farthest-first so the nearest set bit from i_ptr is the last to win.
  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_pos = ID_W'((int'(i_ptr) + k) % NUM_CH);
      if (i_req[w_pos]) o_idx = w_pos;
    end
  end
endmodule

// File: rtl/irq_hs_arbiter.sv
// Round-robin interrupt handshake controller: picks a channel, runs the
// enable-in / interrupt handshake on it, aborts overlong dwell and counts services.
module irq_hs_arbiter
  import irq_hs_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic              clock,
  input logic              reset,
  irq_hs_arbiter_if.slave  bus
);
  // state    | meaning
  // S_INIT   | post-reset, drive enable-in code once
  // S_WAIT   | idle, enable-in phase; pick leads to S_ENIN
  // S_INTR_1 | idle, interrupt phase; pick leads to S_INTR
  // S_ENIN   | granted, waiting for request to drop
  // S_ENIN_W | enable-in acknowledged, waiting to complete
  // S_INTR   | granted, waiting for request to drop
  // S_INTR_W | interrupt acknowledged, waiting to complete
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           r_state;
  logic [1:0]       r_cc_mux;
  logic [1:0]       r_uscite;
  logic             r_enable_count;
  logic             r_ackout;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [DW-1:0]    r_dwell;
  logic             r_busy;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_svc_count;

  logic             w_found;
  logic [ID_W-1:0]  w_idx;
  logic             w_g;
  logic             w_busy_st;
  logic             w_timeout;
  logic [ID_W-1:0]  w_next_ptr;

  rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_g        = bus.req[r_grant_id];
  assign w_busy_st  = (r_state == S_ENIN) || (r_state == S_ENIN_W) ||
                      (r_state == S_INTR) || (r_state == S_INTR_W);
  assign w_timeout  = (TIMEOUT > 0) && w_busy_st && w_g && (r_dwell == DW'(TIMEOUT - 1));
  assign w_next_ptr = (r_grant_id == ID_W'(NUM_CH - 1)) ? '0 : r_grant_id + 1'b1;

  // Defaults at the top are overridden by whichever branch fires; any
  // branch that changes state also clears the dwell counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_INIT;
      r_cc_mux       <= 2'b00;
      r_uscite       <= 2'b00;
      r_enable_count <= 1'b0;
      r_ackout       <= 1'b0;
      r_grant_id     <= '0;
      r_rr_ptr       <= '0;
      r_dwell        <= '0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_svc_count    <= '0;
    end else begin
      r_ackout       <= ~bus.cont_eql;
      r_enable_count <= ~bus.cont_eql;
      r_timeout_err  <= 1'b0;
      r_dwell        <= r_dwell + 1'b1;
      if (w_timeout) begin
        r_state       <= S_WAIT;
        r_uscite      <= OUT_NORM;
        r_cc_mux      <= CC_ENIN;
        r_rr_ptr      <= w_next_ptr;
        r_timeout_err <= 1'b1;
        r_busy        <= 1'b0;
        r_dwell       <= '0;
      end else begin
        unique case (r_state)
          S_INIT: begin
            r_state  <= S_WAIT;
            r_cc_mux <= CC_ENIN;
            r_uscite <= OUT_NORM;
            r_busy   <= 1'b0;
            r_dwell  <= '0;
          end
          S_WAIT, S_INTR_1: begin
            r_dwell <= '0;
            if (w_found) begin
              r_grant_id <= w_idx;
              r_uscite   <= US_HOLD;
              r_cc_mux   <= CC_ACKIN;
              r_busy     <= 1'b1;
              r_state    <= (r_state == S_WAIT) ? S_ENIN : S_INTR;
            end else begin
              r_uscite <= OUT_NORM;
              r_busy   <= 1'b0;
              r_cc_mux <= (r_state == S_WAIT) ? CC_INTR : CC_ENIN;
              r_state  <= (r_state == S_WAIT) ? S_INTR_1 : S_WAIT;
            end
          end
          S_ENIN: begin
            if (w_g) begin
              r_uscite <= US_HOLD;
              r_cc_mux <= CC_ACKIN;
            end else begin
              r_uscite       <= OUT_NORM;
              r_cc_mux       <= CC_ENIN;
              r_ackout       <= 1'b1;
              r_enable_count <= 1'b1;
              r_state        <= S_ENIN_W;
              r_dwell        <= '0;
            end
          end
          S_INTR: begin
            if (w_g) begin
              r_uscite <= US_HOLD;
              r_cc_mux <= CC_ACKIN;
            end else begin
              r_uscite <= US_INTR;
              r_cc_mux <= CC_INTR;
              r_state  <= S_INTR_W;
              r_dwell  <= '0;
            end
          end
          S_ENIN_W, S_INTR_W: begin
            if (w_g) begin
              r_uscite <= (r_state == S_ENIN_W) ? OUT_NORM : US_INTR;
              r_cc_mux <= (r_state == S_ENIN_W) ? CC_ENIN : CC_INTR;
            end else begin
              r_rr_ptr    <= w_next_ptr;
              r_svc_count <= r_svc_count + 1'b1;
              r_uscite    <= OUT_NORM;
              r_cc_mux    <= CC_ENIN;
              r_busy      <= 1'b0;
              r_state     <= S_WAIT;
              r_dwell     <= '0;
            end
          end
          default: begin
            r_state <= S_INIT;
            r_busy  <= 1'b0;
            r_dwell <= '0;
          end
        endcase
      end
    end
  end

  assign bus.cc_mux       = r_cc_mux;
  assign bus.uscite       = r_uscite;
  assign bus.enable_count = r_enable_count;
  assign bus.ackout       = r_ackout;
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = r_busy;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.svc_count    = r_svc_count;
endmodule

// File: tb/tb_irq_hs_arbiter.sv
// Self-checking bench for irq_hs_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a behavioural reference model.
module tb_irq_hs_arbiter;
  localparam int N  = 4;
  localparam int TO = 4;
  localparam int CW = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  irq_hs_arbiter_if #(.NUM_CH(N), .CNT_W(CW)) bus ();

  irq_hs_arbiter #(.NUM_CH(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, phase numbering private to the bench.
  localparam int P_INIT = 0, P_WAIT = 1, P_INTR1 = 2, P_ENIN = 3,
                 P_ENINW = 4, P_INTR = 5, P_INTRW = 6;
  int         m_state, m_gid, m_rr, m_dwell, m_svc;
  logic [1:0] m_cc, m_us;
  bit         m_ack, m_en, m_terr;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_step(input bit rst, input logic [N-1:0] r, input bit ce);
    int nxt;
    int p;
    bit g;
    if (rst) begin
      m_state = P_INIT; m_cc = 2'd0; m_us = 2'd0; m_ack = 0; m_en = 0;
      m_gid = 0; m_rr = 0; m_dwell = 0; m_terr = 0; m_svc = 0;
      return;
    end
    nxt = m_state; m_ack = !ce; m_en = !ce; m_terr = 0;
    g = r[m_gid];
    p = pick(r, m_rr);
    if (m_state >= P_ENIN && g && m_dwell == TO - 1) begin
      nxt = P_WAIT; m_us = 2'd1; m_cc = 2'd1; m_rr = (m_gid + 1) % N; m_terr = 1;
    end else begin
      case (m_state)
        P_INIT: begin nxt = P_WAIT; m_cc = 2'd1; m_us = 2'd1; end
        P_WAIT, P_INTR1: begin
          if (p >= 0) begin
            m_gid = p; m_us = 2'd0; m_cc = 2'd3;
            nxt = (m_state == P_WAIT) ? P_ENIN : P_INTR;
          end else begin
            m_us = 2'd1;
            m_cc = (m_state == P_WAIT) ? 2'd2 : 2'd1;
            nxt  = (m_state == P_WAIT) ? P_INTR1 : P_WAIT;
          end
        end
        P_ENIN: begin
          if (g) begin m_us = 2'd0; m_cc = 2'd3; end
          else begin m_us = 2'd1; m_cc = 2'd1; m_ack = 1; m_en = 1; nxt = P_ENINW; end
        end
        P_INTR: begin
          if (g) begin m_us = 2'd0; m_cc = 2'd3; end
          else begin m_us = 2'd3; m_cc = 2'd2; nxt = P_INTRW; end
        end
        default: begin
          if (g) begin
            m_us = (m_state == P_ENINW) ? 2'd1 : 2'd3;
            m_cc = (m_state == P_ENINW) ? 2'd1 : 2'd2;
          end else begin
            m_rr = (m_gid + 1) % N; m_svc = (m_svc + 1) % (1 << CW);
            m_us = 2'd1; m_cc = 2'd1; nxt = P_WAIT;
          end
        end
      endcase
    end
    m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
    m_state = nxt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model consumes the inputs present at the edge, outputs compared #1 later.
  task automatic step();
    bit            rs;
    logic [N-1:0]  r;
    bit            ce;
    rs = reset; r = bus.req; ce = bus.cont_eql;
    @(posedge clock);
    model_step(rs, r, ce);
    #1;
    chk("m_cc_mux", bus.cc_mux, m_cc);
    chk("m_uscite", bus.uscite, m_us);
    chk("m_ackout", bus.ackout, m_ack);
    chk("m_enable_count", bus.enable_count, m_en);
    chk("m_grant_id", bus.grant_id, m_gid);
    chk("m_busy", bus.busy, m_state >= P_ENIN);
    chk("m_timeout_err", bus.timeout_err, m_terr);
    chk("m_svc_count", bus.svc_count, m_svc);
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = '0; bus.cont_eql = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  typedef struct {
    bit rst; logic [3:0] req; bit ce;
    logic [1:0] cc; logic [1:0] us; bit ack; bit en;
    int gid; bit busy; bit terr; int svc;
  } vec_t;
  vec_t tbl[11];

  function automatic vec_t mk(bit rst, logic [3:0] req, bit ce, logic [1:0] cc,
                              logic [1:0] us, bit ack, bit en, int gid, bit busy,
                              bit terr, int svc);
    vec_t v;
    v.rst = rst; v.req = req; v.ce = ce; v.cc = cc; v.us = us; v.ack = ack;
    v.en = en; v.gid = gid; v.busy = busy; v.terr = terr; v.svc = svc;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    int exp_rr[5];
    bit ok;
    int nbusy;
    bit prev_busy;

    reset = 1'b1; bus.req = '0; bus.cont_eql = 1'b1;

    tbl[0]  = mk(1, 4'b0000, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4'b0000, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 4'b0000, 1, 2'd1, 2'd1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 4'b0000, 1, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 4'b0000, 1, 2'd1, 2'd1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 4'b0010, 1, 2'd3, 2'd0, 0, 0, 1, 1, 0, 0);
    tbl[6]  = mk(0, 4'b0010, 1, 2'd3, 2'd0, 0, 0, 1, 1, 0, 0);
    tbl[7]  = mk(0, 4'b0010, 1, 2'd3, 2'd0, 0, 0, 1, 1, 0, 0);
    tbl[8]  = mk(0, 4'b0000, 1, 2'd1, 2'd1, 1, 1, 1, 1, 0, 0);
    tbl[9]  = mk(0, 4'b0000, 1, 2'd1, 2'd1, 0, 0, 1, 0, 0, 1);
    tbl[10] = mk(0, 4'b1111, 0, 2'd3, 2'd0, 1, 1, 2, 1, 0, 1);

    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; bus.req = tbl[i].req; bus.cont_eql = tbl[i].ce;
      step();
      chk($sformatf("tbl%0d_cc", i), bus.cc_mux, tbl[i].cc);
      chk($sformatf("tbl%0d_us", i), bus.uscite, tbl[i].us);
      chk($sformatf("tbl%0d_ack", i), bus.ackout, tbl[i].ack);
      chk($sformatf("tbl%0d_en", i), bus.enable_count, tbl[i].en);
      chk($sformatf("tbl%0d_gid", i), bus.grant_id, tbl[i].gid);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("tbl%0d_terr", i), bus.timeout_err, tbl[i].terr);
      chk($sformatf("tbl%0d_svc", i), bus.svc_count, tbl[i].svc);
    end

    // Round robin with all requests held: every channel gets its turn in order.
    do_reset();
    bus.req = 4'b1111; bus.cont_eql = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < 200 && gq.size() < 5; i++) begin
      step();
      if (bus.busy && !prev_busy) gq.push_back(int'(bus.grant_id));
      prev_busy = bus.busy;
    end
    chk("rr_seq_len", gq.size(), 5);
    exp_rr = '{0, 1, 2, 3, 0};
    for (int i = 0; i < gq.size() && i < 5; i++)
      chk($sformatf("rr_seq%0d", i), gq[i], exp_rr[i]);

    // Stuck request on channel 2 is aborted after TO dwell cycles.
    do_reset();
    bus.req = 4'b0100;
    ok = 0; nbusy = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      if (bus.busy) nbusy++;
      if (bus.timeout_err) ok = 1;
    end
    chk("to_seen", ok, 1);
    chk("to_busy_cycles", nbusy, TO);
    chk("to_svc_unchanged", bus.svc_count, 0);
    chk("to_gid", bus.grant_id, 2);
    bus.req = 4'b1100;
    step();
    chk("to_pulse_once", bus.timeout_err, 0);
    chk("to_next_grant", bus.grant_id, 3);
    chk("to_next_busy", bus.busy, 1);

    // Reset asserted while in the interrupt wait state.
    do_reset();
    step(); step();
    bus.req = 4'b0100;
    step();
    chk("iw_pick_us", bus.uscite, 2'b00);
    bus.req = 4'b0000;
    step();
    chk("iw_us", bus.uscite, 2'b11);
    chk("iw_cc", bus.cc_mux, 2'b10);
    bus.req = 4'b0100; reset = 1'b1;
    step();
    chk("iw_rst_cc", bus.cc_mux, 2'b00);
    chk("iw_rst_us", bus.uscite, 2'b00);
    chk("iw_rst_ack", bus.ackout, 0);
    chk("iw_rst_gid", bus.grant_id, 0);
    chk("iw_rst_busy", bus.busy, 0);
    reset = 1'b0; bus.req = 4'b0000;
    step();
    chk("iw_init_cc", bus.cc_mux, 2'b01);

    // Five completions on a 2-bit counter wrap to 1.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus.req = 4'b0001; bus.cont_eql = c[0];
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin step(); ok = bus.busy; end
      chk($sformatf("wrap_grant%0d", c), ok, 1);
      bus.req = 4'b0000;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin step(); ok = !bus.busy; end
      chk($sformatf("wrap_done%0d", c), ok, 1);
    end
    chk("wrap_svc", bus.svc_count, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) bus.req = '0;
      bus.cont_eql = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_hs_arbiter.md
Name: irq_hs_arbiter

Overview:
- Multi-channel interrupt handshake controller; parametrised successor of the single-line eql/cont_eql interrupt handler FSM.
- Arbitrates NUM_CH request lines round-robin and runs the enable-in / interrupt handshake sequence on the granted channel.
- Bounds handshake dwell time with a timeout and counts completed services.
- Sits between peripheral request lines and the interrupt mux (cc_mux) and status (uscite) logic.

Parameters:
- NUM_CH, 4, number of request channels (1..16).
- TIMEOUT, 16, maximum dwell cycles in a handshake state; 0 disables the timeout.
- CNT_W, 8, width of the completed-service counter.
- ID_W, derived as max(1, clog2(NUM_CH)), width of the grant id.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel request/equality lines (the generalised eql).
- cont_eql  in  1  counter-equal; drives ackout/enable_count.
- cc_mux  out  2  mux control code.
- uscite  out  2  status code.
- enable_count  out  1  counter enable.
- ackout  out  1  acknowledge out.
- grant_id  out  ID_W  currently granted channel.
- busy  out  1  high in S_ENIN, S_ENIN_W, S_INTR, S_INTR_W.
- timeout_err  out  1  one-cycle pulse on a forced abort.
- svc_count  out  CNT_W  completed services; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered. Reset values: state=S_INIT, cc_mux=00, uscite=00, enable_count=0, ackout=0, grant_id=0, rr_ptr=0, dwell=0, timeout_err=0, svc_count=0.
- Reset wins over all other events on every cycle, including mid-handshake.
- Codes: CC_ENIN=01, CC_INTR=10, CC_ACKIN=11; OUT_NORM=01.
- Every non-reset cycle: ackout = enable_count = ~cont_eql, unless overridden by a transition rule below.
- Let any_req = |req. Let g = req[grant_id].
- pick: first set bit of req scanning circularly from rr_ptr upward. A pick loads grant_id.
- Completion: grant_id unchanged; rr_ptr <= (grant_id+1) mod NUM_CH.
- S_INIT -> S_WAIT; cc_mux=CC_ENIN, uscite=OUT_NORM.
- S_WAIT:
  - any_req: pick; uscite=00, cc_mux=CC_ACKIN; -> S_ENIN.
  - else: uscite=OUT_NORM, cc_mux=CC_INTR; -> S_INTR_1.
- S_INTR_1:
  - any_req: pick; uscite=00, cc_mux=CC_ACKIN; -> S_INTR.
  - else: uscite=OUT_NORM, cc_mux=CC_ENIN; -> S_WAIT.
- S_ENIN:
  - g: stay; uscite=00, cc_mux=CC_ACKIN.
  - else: uscite=01, cc_mux=CC_ENIN, ackout=1 and enable_count=1 regardless of cont_eql; -> S_ENIN_W.
- S_ENIN_W:
  - g: stay; uscite=01, cc_mux=CC_ENIN.
  - else: completion, svc_count+1; uscite=OUT_NORM, cc_mux=CC_ENIN; -> S_WAIT.
- S_INTR:
  - g: stay; uscite=00, cc_mux=CC_ACKIN.
  - else: uscite=11, cc_mux=CC_INTR; -> S_INTR_W.
- S_INTR_W:
  - g: stay; uscite=11, cc_mux=CC_INTR.
  - else: completion, svc_count+1; uscite=OUT_NORM, cc_mux=CC_ENIN; -> S_WAIT.
- Requests on non-granted channels are ignored while busy. They are not latched, only resampled at the next pick.
- dwell counter:
  - Clears on every state change; increments each cycle the state holds.
  - If TIMEOUT>0, state is one of the four busy states, g=1 and dwell==TIMEOUT-1: force -> S_WAIT with uscite=OUT_NORM, cc_mux=CC_ENIN.
  - On that forced abort: timeout_err=1 for exactly one cycle, rr_ptr advances past grant_id, svc_count unchanged.
  - Timeout has priority over the stay branch.
- svc_count wraps from 2^CNT_W-1 to 0.
- NUM_CH=1: rr_ptr is held at 0 and pick always selects channel 0.

Decomposition:
- Package irq_hs_pkg: state enum (S_INIT, S_WAIT, S_ENIN, S_ENIN_W, S_INTR, S_INTR_1, S_INTR_W), cc_mux codes, OUT_NORM, and the uscite codes 00/11.
- One sub-module rr_pick (combinational: req and rr_ptr in, found and idx out) holds the arbitration logic and is unit-testable on its own.

Test Plan:
- Reset for 2 cycles, release with req=0 -> S_INIT, then S_WAIT/S_INTR_1 alternation; cc_mux toggles 10/01; uscite=01; svc_count=0.
- req=0010 in S_WAIT, held 3 cycles, then dropped -> grant_id=1, uscite 00 (x3), then 01, then 01 -> S_WAIT; svc_count=1; rr_ptr=2.
- req=1111 held continuously through repeated services -> grant_id sequence 0,1,2,3,0; no channel is skipped.
- TIMEOUT=4, req[2] stuck high -> forced to S_WAIT after 4 dwell cycles in S_ENIN; timeout_err pulses once; svc_count unchanged; next grant is channel 3.
- cont_eql=1 on the S_ENIN -> S_ENIN_W cycle -> ackout=enable_count=1 that cycle, 0 on the following cycle.
- reset asserted in S_INTR_W -> next cycle all outputs at reset values and state=S_INIT; CNT_W=2 with 5 completions -> svc_count=1.
